// File: rtl/me_control_if.sv
// me_control_if: count-enable input and sequencer outputs of the motion-estimator control block
interface me_control_if;
  logic        start;
  logic [15:0] S1S2mux;
  logic [15:0] newDist;
  logic [15:0] PEready;
  logic        CompStart;
  logic [3:0]  VectorX;
  logic [3:0]  VectorY;
  logic [7:0]  AddressR;
  logic [9:0]  AddressS1;
  logic [9:0]  AddressS2;
  modport master(output start, input S1S2mux, newDist, PEready, CompStart, VectorX, VectorY,
                 AddressR, AddressS1, AddressS2);
  modport slave(input start, output S1S2mux, newDist, PEready, CompStart, VectorX, VectorY,
                AddressR, AddressS1, AddressS2);
endinterface

// File: rtl/me_control.sv
// me_control: single-counter sequencer for a 16-PE full-search block-matching motion estimator
module me_control (
  input logic        clock,
  input logic        reset,
  me_control_if.slave bus
);
  logic [12:0] count_q, count_d;
  logic [3:0]  vx_q, vx_d, vy_q, vy_d;
  logic [3:0]  c, r, y;
  logic [4:0]  row5;
  logic        run, comp, pe_any;
  assign c    = count_q[3:0];
  assign r    = count_q[7:4];
  assign y    = count_q[11:8];
  assign row5 = {1'b0, y} + {1'b0, r};
  assign run  = count_q < 13'd4112;
  assign comp = run && count_q >= 13'd256;
  genvar i;
  for (i = 0; i < 16; i++) begin : g_pe
    assign bus.S1S2mux[i] = c >= 4'(i);
    assign bus.newDist[i] = (count_q[7:0] == 8'(i)) && run;
  end
  assign bus.PEready   = bus.newDist & {16{comp}};
  assign bus.CompStart = comp;
  assign bus.AddressR  = count_q[7:0];
  assign bus.AddressS1 = {row5, 1'b0, c};
  assign bus.AddressS2 = {row5, 1'b1, c};
  assign bus.VectorX   = vx_q;
  assign bus.VectorY   = vy_q;
  assign pe_any        = |bus.PEready;
  always_comb begin
    count_d = (bus.start && run) ? count_q + 13'd1 : count_q;
    vx_d    = pe_any ? c : vx_q;
    // first offset row is presented while count[11:8] is already 1
    vy_d    = pe_any ? y - 4'd1 : vy_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
      vx_q    <= '0;
      vy_q    <= '0;
    end else begin
      count_q <= count_d;
      vx_q    <= vx_d;
      vy_q    <= vy_d;
    end
  end
endmodule

// File: tb/tb_me_control.sv
// tb_me_control: scoreboard bench comparing me_control outputs against a behavioural count model
module tb_me_control;
  logic clock = 1'b0;
  logic reset;
  me_control_if bus();
  me_control dut (.clock(clock), .reset(reset), .bus(bus.slave));
  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] mux, nd, pr;
    logic        cs;
    logic [3:0]  vx, vy;
    logic [7:0]  ar;
    logic [9:0]  a1, a2;
    logic        addr_ok;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   m_cnt = 0;
  int   m_vx  = 0;
  int   m_vy  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s at model count %0d: got %0h, want %0h", tag, m_cnt, obs, exp);
    end
  endtask

  function automatic exp_t model(input int cnt, input int vx, input int vy);
    exp_t e;
    int col, row;
    col = cnt % 16;
    row = (cnt / 256) % 16 + (cnt / 16) % 16;
    e.mux = 16'h0;
    for (int k = 0; k <= col; k++) e.mux[k] = 1'b1;
    e.nd  = (cnt < 4112 && cnt % 256 < 16) ? 16'(1 << (cnt % 256)) : 16'h0;
    e.pr  = (cnt >= 256) ? e.nd : 16'h0;
    e.cs  = cnt >= 256 && cnt < 4112;
    e.vx  = 4'(vx);
    e.vy  = 4'(vy);
    e.ar  = 8'(cnt % 256);
    e.a1  = 10'(row * 32 + col);
    e.a2  = 10'(row * 32 + col + 16);
    e.addr_ok = cnt < 4096;
    return e;
  endfunction

  task automatic step(input logic st, input logic rs);
    exp_t e;
    bit   ready;
    bus.start = st;
    reset     = rs;
    ready = m_cnt >= 256 && m_cnt < 4112 && m_cnt % 256 < 16;
    @(posedge clock);
    if (rs) begin
      m_cnt = 0; m_vx = 0; m_vy = 0;
    end else begin
      if (ready) begin
        m_vx = m_cnt % 16;
        m_vy = (m_cnt / 256 + 15) % 16;
      end
      if (st && m_cnt < 4112) m_cnt++;
    end
    q.push_back(model(m_cnt, m_vx, m_vy));
    #1;
    if (q.size() == 0) begin
      check("sb_empty", 1, 0);
    end else begin
      e = q.pop_front();
      check("S1S2mux", 32'(bus.S1S2mux), 32'(e.mux));
      check("newDist", 32'(bus.newDist), 32'(e.nd));
      check("PEready", 32'(bus.PEready), 32'(e.pr));
      check("CompStart", 32'(bus.CompStart), 32'(e.cs));
      check("VectorX", 32'(bus.VectorX), 32'(e.vx));
      check("VectorY", 32'(bus.VectorY), 32'(e.vy));
      if (e.addr_ok) begin
        check("AddressR", 32'(bus.AddressR), 32'(e.ar));
        check("AddressS1", 32'(bus.AddressS1), 32'(e.a1));
        check("AddressS2", 32'(bus.AddressS2), 32'(e.a2));
      end
    end
    if (m_cnt == 0 && !rs && !st) check("idle_s2", 32'(bus.AddressS2), 16);
    if (m_cnt == 17) begin
      check("c17_ar", 32'(bus.AddressR), 17);
      check("c17_s1", 32'(bus.AddressS1), 33);
      check("c17_s2", 32'(bus.AddressS2), 49);
      check("c17_mux", 32'(bus.S1S2mux), 32'h3);
    end
    if (m_cnt == 256) check("c256_pr", 32'(bus.PEready), 32'h1);
    if (m_cnt == 259) check("c259_pr", 32'(bus.PEready), 32'h8);
    if (m_cnt == 260) check("c260_vx", 32'(bus.VectorX), 3);
    if (m_cnt == 4111) check("c4111_pr", 32'(bus.PEready), 32'h8000);
    if (m_cnt == 4112) begin
      check("done_vx", 32'(bus.VectorX), 15);
      check("done_vy", 32'(bus.VectorY), 15);
      check("done_cs", 32'(bus.CompStart), 0);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    reset     = 1'b1;
    repeat (2) step(1'b0, 1'b1);
    repeat (10) step(1'b0, 1'b0);
    while (m_cnt < 1000) step(1'b1, 1'b0);
    repeat (5) step(1'b0, 1'b0);
    check("freeze_cnt", 32'(m_cnt), 1000);
    while (m_cnt < 3000) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    check("rst_cs", 32'(bus.CompStart), 0);
    while (m_cnt < 4112) step(1'b1, 1'b0);
    repeat (20) step(1'b1, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
